// File: rtl/etch_pkg.sv
// Shared geometry, FSM state type and cell-to-address mapping for the trace frame buffer.
// Also used by the pixel generator so reads and writes agree on the layout.
package etch_pkg;

    localparam int X_CELLS  = 160;
    localparam int Y_CELLS  = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int A_W      = 15;
    localparam int PEND_MAX = 7;
    localparam int PEND_W   = 4;
    localparam int FB_CELLS = X_CELLS * Y_CELLS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_WRITE,
        ST_CLEAR
    } state_t;

    // y*160 built as (y<<7)+(y<<5) so no multiplier is inferred
    function automatic logic [A_W-1:0] cell_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        logic [A_W-1:0] ye;
        ye = A_W'(y);
        return (ye << 7) + (ye << 5) + A_W'(x);
    endfunction

endpackage

// File: rtl/step_accum.sv
// Saturating signed pending-step counter for one axis; consume moves it one unit toward zero.
module step_accum
    import etch_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     dec,
    input  logic                     consume,
    output logic signed [PEND_W-1:0] pend
);

    localparam logic signed [PEND_W:0] SAT_HI = (PEND_W + 1)'(PEND_MAX);
    localparam logic signed [PEND_W:0] SAT_LO = -SAT_HI;
    localparam logic signed [PEND_W:0] ONE    = (PEND_W + 1)'(1);

    logic signed [PEND_W:0] adj;
    logic signed [PEND_W:0] sum;

    always_comb begin
        adj = '0;
        if (inc) adj = adj + ONE;
        if (dec) adj = adj - ONE;
        // a pulse landing on the consume cycle is still counted
        if (consume) begin
            if (pend[PEND_W-1])     adj = adj + ONE;
            else if (pend != '0)    adj = adj - ONE;
        end
        sum = {pend[PEND_W-1], pend} + adj;
        if (sum > SAT_HI)      sum = SAT_HI;
        else if (sum < SAT_LO) sum = SAT_LO;
    end

    always_ff @(posedge clk) begin
        if (reset) pend <= '0;
        else       pend <= sum[PEND_W-1:0];
    end

endmodule

// File: rtl/etch_cursor_ctrl.sv
// Cursor sequencer: turns encoder step pulses into cursor moves and trail writes,
// and sweeps the whole trace buffer to zero on clear or after reset.
//   state    | meaning
//   ST_IDLE  | waiting for clear request or pending steps
//   ST_MOVE  | apply one unit per axis toward pending sign
//   ST_WRITE | ink the cursor cell, hold until accepted
//   ST_CLEAR | erase sweep over every cell
module etch_cursor_ctrl
    import etch_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           step_up,
    input  logic           step_down,
    input  logic           step_left,
    input  logic           step_right,
    input  logic           trace_en,
    input  logic           clear_req,
    input  logic           fb_wr_ready,
    output logic           fb_wr_en,
    output logic [A_W-1:0] fb_wr_addr,
    output logic           fb_wr_data,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic           busy
);

    localparam logic [X_W-1:0] X_HOME  = X_W'(X_CELLS / 2);
    localparam logic [Y_W-1:0] Y_HOME  = Y_W'(Y_CELLS / 2);
    localparam logic [X_W-1:0] X_LAST  = X_W'(X_CELLS - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(Y_CELLS - 1);
    localparam logic [A_W-1:0] FB_LAST = A_W'(FB_CELLS - 1);

    state_t                   state;
    logic                     clear_pend;
    logic [A_W-1:0]           sweep;
    logic signed [PEND_W-1:0] pend_x;
    logic signed [PEND_W-1:0] pend_y;
    logic                     x_neg, x_pos, y_neg, y_pos;
    logic                     consume_x, consume_y;
    logic [X_W-1:0]           nx;
    logic [Y_W-1:0]           ny;

    assign x_neg     = pend_x[PEND_W-1];
    assign x_pos     = !x_neg && (pend_x != '0);
    assign y_neg     = pend_y[PEND_W-1];
    assign y_pos     = !y_neg && (pend_y != '0);
    assign consume_x = (state == ST_MOVE) && (pend_x != '0);
    assign consume_y = (state == ST_MOVE) && (pend_y != '0);

    step_accum u_acc_x (
        .clk     (clk),
        .reset   (reset),
        .inc     (step_right),
        .dec     (step_left),
        .consume (consume_x),
        .pend    (pend_x)
    );

    step_accum u_acc_y (
        .clk     (clk),
        .reset   (reset),
        .inc     (step_down),
        .dec     (step_up),
        .consume (consume_y),
        .pend    (pend_y)
    );

    // at a screen edge the cursor holds but the unit is still consumed
    always_comb begin
        nx = cur_x;
        ny = cur_y;
        if (x_pos && (cur_x != X_LAST))     nx = cur_x + X_W'(1);
        else if (x_neg && (cur_x != '0))    nx = cur_x - X_W'(1);
        if (y_pos && (cur_y != Y_LAST))     ny = cur_y + Y_W'(1);
        else if (y_neg && (cur_y != '0))    ny = cur_y - Y_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CLEAR;
            cur_x      <= X_HOME;
            cur_y      <= Y_HOME;
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= 1'b0;
            clear_pend <= 1'b0;
            sweep      <= '0;
            busy       <= 1'b1;
        end else begin
            if (clear_req) clear_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (clear_pend) begin
                        state      <= ST_CLEAR;
                        clear_pend <= 1'b0;
                        sweep      <= '0;
                        fb_wr_en   <= 1'b1;
                        fb_wr_addr <= '0;
                        fb_wr_data <= 1'b0;
                        busy       <= 1'b1;
                    end else if ((pend_x != '0) || (pend_y != '0)) begin
                        state <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    cur_x <= nx;
                    cur_y <= ny;
                    if (trace_en) begin
                        state      <= ST_WRITE;
                        fb_wr_en   <= 1'b1;
                        fb_wr_addr <= cell_addr(nx, ny);
                        fb_wr_data <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (fb_wr_ready) begin
                        fb_wr_en <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    // after reset the request is raised one cycle into the sweep
                    if (!fb_wr_en) begin
                        fb_wr_en   <= 1'b1;
                        fb_wr_addr <= sweep;
                        fb_wr_data <= 1'b0;
                    end else if (fb_wr_ready) begin
                        if (sweep == FB_LAST) begin
                            busy <= 1'b0;
                            if (trace_en) begin
                                state      <= ST_WRITE;
                                fb_wr_addr <= cell_addr(cur_x, cur_y);
                                fb_wr_data <= 1'b1;
                            end else begin
                                state    <= ST_IDLE;
                                fb_wr_en <= 1'b0;
                            end
                        end else begin
                            sweep      <= sweep + A_W'(1);
                            fb_wr_addr <= sweep + A_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_etch_cursor_ctrl.sv
// Randomized self-checking bench for etch_cursor_ctrl against a cell-level cursor/write model.
module tb_etch_cursor_ctrl;

    localparam int XC = 160;
    localparam int YC = 120;
    localparam int NCELL = XC * YC;

    logic        clk = 1'b0;
    logic        reset, step_up, step_down, step_left, step_right;
    logic        trace_en, clear_req, fb_wr_ready;
    logic        fb_wr_en, fb_wr_data, busy;
    logic [14:0] fb_wr_addr;
    logic [7:0]  cur_x;
    logic [6:0]  cur_y;

    always #5 clk = ~clk;

    etch_cursor_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .step_up     (step_up),
        .step_down   (step_down),
        .step_left   (step_left),
        .step_right  (step_right),
        .trace_en    (trace_en),
        .clear_req   (clear_req),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_en    (fb_wr_en),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .busy        (busy)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  n_xfer   = 0;
    int  mx = 80;
    int  my = 60;
    bit  rdy_rand = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void push_wr(input int a, input int d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) fb_wr_ready = ($urandom_range(0, 3) != 0);
    endtask

    // dir: 0 up, 1 down, 2 left, 3 right, 4 up+down, 5 left+right
    task automatic pulse(input int dir);
        tick();
        step_up    = (dir == 0) || (dir == 4);
        step_down  = (dir == 1) || (dir == 4);
        step_left  = (dir == 2) || (dir == 5);
        step_right = (dir == 3) || (dir == 5);
        tick();
        step_up = 1'b0; step_down = 1'b0; step_left = 1'b0; step_right = 1'b0;
    endtask

    function automatic void model_step(input int dir);
        int dx, dy;
        dx = (dir == 3) ? 1 : (dir == 2) ? -1 : 0;
        dy = (dir == 1) ? 1 : (dir == 0) ? -1 : 0;
        if (dx == 0 && dy == 0) return;
        mx = mx + dx;
        my = my + dy;
        if (mx < 0) mx = 0;
        if (mx > XC - 1) mx = XC - 1;
        if (my < 0) my = 0;
        if (my > YC - 1) my = YC - 1;
        if (trace_en) push_wr(my * XC + mx, 1);
    endfunction

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic step(input int dir);
        model_step(dir);
        pulse(dir);
        wait_drain(200, "step_drain");
        repeat (4) tick();
    endtask

    task automatic push_sweep();
        for (int a = 0; a < NCELL; a++) push_wr(a, 0);
    endtask

    // write monitor: in-order scoreboard plus hold-while-stalled rule
    initial begin
        logic        stall;
        logic [14:0] s_addr;
        logic        s_data;
        wr_t         w;
        stall = 1'b0;
        s_addr = '0;
        s_data = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_en", int'(fb_wr_en), 1);
                    check("hold_addr", int'(fb_wr_addr), int'(s_addr));
                    check("hold_data", int'(fb_wr_data), int'(s_data));
                end
                if (fb_wr_en && fb_wr_ready) begin
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_wr", int'(fb_wr_addr), -1);
                    end else begin
                        w = exp_q.pop_front();
                        check("wr_addr", int'(fb_wr_addr), w.addr);
                        check("wr_data", int'(fb_wr_data), w.data);
                    end
                end
                stall  = fb_wr_en && !fb_wr_ready;
                s_addr = fb_wr_addr;
                s_data = fb_wr_data;
            end
        end
    end

    initial begin
        int x0, a0, n;
        reset = 1'b1;
        step_up = 1'b0; step_down = 1'b0; step_left = 1'b0; step_right = 1'b0;
        clear_req = 1'b0;
        trace_en = 1'b1;
        fb_wr_ready = 1'b1;
        repeat (3) tick();
        check("rst_cur_x", int'(cur_x), 80);
        check("rst_cur_y", int'(cur_y), 60);
        check("rst_wr_en", int'(fb_wr_en), 0);
        check("rst_addr", int'(fb_wr_addr), 0);
        check("rst_busy", int'(busy), 1);

        // power-up sweep then cursor dot
        push_sweep();
        push_wr(60 * XC + 80, 1);
        reset = 1'b0;
        wait_drain(20000, "sweep1_drain");
        repeat (3) tick();
        check("sweep1_busy", int'(busy), 0);
        check("sweep1_wr_en", int'(fb_wr_en), 0);

        // three right steps with trail
        for (int i = 1; i <= 3; i++) begin
            step(3);
            check("right_x", int'(cur_x), 80 + i);
        end

        // right edge
        trace_en = 1'b0;
        while (mx < XC - 1) step(3);
        check("edge_r_x", int'(cur_x), XC - 1);
        trace_en = 1'b1;
        step(3);
        step(3);
        check("edge_r_hold", int'(cur_x), XC - 1);
        step(2);
        check("edge_r_back", int'(cur_x), XC - 2);

        // left, top and bottom edges
        trace_en = 1'b0;
        while (mx > 0) step(2);
        step(2);
        check("edge_l_hold", int'(cur_x), 0);
        step(3);
        check("edge_l_back", int'(cur_x), 1);
        while (my > 0) step(0);
        step(0);
        check("edge_t_hold", int'(cur_y), 0);
        step(1);
        check("edge_t_back", int'(cur_y), 1);
        while (my < YC - 1) step(1);
        step(1);
        check("edge_b_hold", int'(cur_y), YC - 1);
        step(0);
        check("edge_b_back", int'(cur_y), YC - 2);

        // write stalled by fb_wr_ready low
        trace_en = 1'b1;
        fb_wr_ready = 1'b0;
        x0 = n_xfer;
        model_step(2);
        pulse(2);
        n = 0;
        while (!fb_wr_en && n < 10) begin
            tick();
            n++;
        end
        check("stall_wr_en", int'(fb_wr_en), 1);
        a0 = int'(fb_wr_addr);
        check("stall_addr", a0, my * XC + mx);
        repeat (5) begin
            tick();
            check("stall_en_hold", int'(fb_wr_en), 1);
            check("stall_addr_hold", int'(fb_wr_addr), a0);
            check("stall_data_hold", int'(fb_wr_data), 1);
        end
        check("stall_no_xfer", n_xfer - x0, 0);
        fb_wr_ready = 1'b1;
        wait_drain(20, "stall_drain");
        repeat (3) tick();
        check("stall_one_xfer", n_xfer - x0, 1);
        check("stall_x", int'(cur_x), mx);

        // opposite pulses cancel
        x0 = n_xfer;
        pulse(4);
        repeat (6) tick();
        check("cancel_no_xfer", n_xfer - x0, 0);
        check("cancel_y", int'(cur_y), my);

        // clear with 10 up steps and a second clear request during the sweep
        push_sweep();
        push_wr(my * XC + mx, 1);
        push_sweep();
        push_wr(my * XC + mx, 1);
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        check("clear_busy", int'(busy), 1);
        repeat (10) pulse(0);
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("clear_busy_mid", int'(busy), 1);
        x0 = my;
        for (int i = 0; i < 7; i++) model_step(0);
        wait_drain(42000, "sweep23_drain");
        repeat (4) tick();
        check("sat_y", int'(cur_y), x0 - 7);
        check("sweep23_busy", int'(busy), 0);

        // random walk with random write back-pressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            trace_en = 1'($urandom_range(0, 1));
            step(int'($urandom_range(0, 5)));
            check("rw_x", int'(cur_x), mx);
            check("rw_y", int'(cur_y), my);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
